// File: rtl/bcd_down_timer.sv
// -----------------------------------------------------------------------------
// bcd_down_timer
//
// Multi-digit BCD down-counter with a small run/pause/done controller, meant
// for kitchen-timer style use (mm:ss when SEC_MODE=1).
//
// Parameters
//   DIGITS   : number of BCD digits, legal range 2..8 (default 4)
//   SEC_MODE : 1 -> digit 1 (tens of seconds) wraps 0->5 on borrow (mm:ss)
//              0 -> every digit wraps 0->9 on borrow
//
// Optional build macro
//   BCD_TIMER_LOAD_CHECK_EN : when defined, every loaded digit above 9 is
//   clamped to 9, and digit 1 above 5 is clamped to 5 when SEC_MODE=1.
//   When undefined, data is loaded exactly as presented.
//
// Ports
//   clk   in   single clock, all state changes on the rising edge
//   clrn  in   synchronous active-low reset (count=0, IDLE, done=0)
//   data  in   [4*DIGITS-1:0] load value, digit 0 in bits [3:0]
//   loadn in   active-low load request (ignored while running)
//   en    in   one-cycle count tick strobe
//   start in   begin / resume counting
//   stop  in   pause; a stop while paused (or done) clears the count
//   count out  [4*DIGITS-1:0] current BCD value
//   state out  [1:0] IDLE=00, RUN=01, PAUSE=10, DONE=11
//   zero  out  high when count is 0 (combinational from count)
//   done  out  registered one-cycle pulse when the count expires
//
// Handshake / strobe semantics: there is no valid/ready pair here. Every
// control input is a level sampled on each rising clk edge; en is expected
// to be a single-cycle strobe, and each cycle it is high while in RUN moves
// the count down by exactly one. When stop, loadn=0 and start coincide, stop
// wins, then load, then start.
// -----------------------------------------------------------------------------
module bcd_down_timer #(
  parameter int DIGITS   = 4,
  parameter int SEC_MODE = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  loadn,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  zero,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic [W-1:0] count_q, count_d;
  logic [1:0]   state_q, state_d;
  logic         done_q,  done_d;

  logic [W-1:0] dec_val;
  logic [W-1:0] load_val;
  logic         cnt_zero;
  logic         dec_zero;

  // Value a digit takes when it borrows from the digit above.
  function automatic logic [3:0] wrap_digit(input int idx);
    if ((SEC_MODE != 0) && (idx == 1)) begin
      return 4'd5;
    end
    return 4'd9;
  endfunction

  // ---------------------------------------------------------------------------
  // BCD decrement with full borrow ripple in one cycle. Each digit is treated
  // as plain binary minus one, borrowing only when it is 0; this keeps the
  // behaviour defined for illegal (>9) digits that were loaded unchecked.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic borrow;
    dec_val = count_q;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = wrap_digit(i);
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load value, optionally clamped to legal BCD digits.
  // ---------------------------------------------------------------------------
`ifdef BCD_TIMER_LOAD_CHECK_EN
  always_comb begin
    logic [3:0] nib;
    load_val = data;
    for (int i = 0; i < DIGITS; i++) begin
      nib = data[4*i +: 4];
      if ((SEC_MODE != 0) && (i == 1) && (nib > 4'd5)) begin
        nib = 4'd5;
      end else if (nib > 4'd9) begin
        nib = 4'd9;
      end
      load_val[4*i +: 4] = nib;
    end
  end
`else
  always_comb begin
    load_val = data;
  end
`endif

  assign cnt_zero = (count_q == '0);
  assign dec_zero = (dec_val == '0);

  // ---------------------------------------------------------------------------
  // Controller. Priority inside each state: stop, then load, then start/en.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        // loadn has no effect while running; stop swallows a same-cycle en.
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (en && !cnt_zero) begin
          count_d = dec_val;
          if (dec_zero) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_IDLE: begin
        // A stop here has nothing to pause or clear beyond what is already
        // idle, but it still outranks a simultaneous load or start.
        if (!stop) begin
          if (!loadn) begin
            count_d = load_val;
          end else if (start && !cnt_zero) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (!loadn) begin
          count_d = load_val;
          state_d = ST_IDLE;
        end else if (start && !cnt_zero) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        // ST_DONE: start is ignored, only stop or a load leaves.
        if (stop) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (!loadn) begin
          count_d = load_val;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      count_q <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign zero  = cnt_zero;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_timer
//
// Drives two timers side by side from the same inputs: one in mm:ss mode
// (SEC_MODE=1) and one in plain decimal mode (SEC_MODE=0), both 4 digits.
// A digit-array reference model tracks the expected count, state and done
// for each, and every cycle all outputs of both timers are compared.
// Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

`ifdef BCD_TIMER_LOAD_CHECK_EN
  localparam bit LOAD_CHK = 1'b1;
`else
  localparam bit LOAD_CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clrn;
  logic         loadn;
  logic         en;
  logic         start;
  logic         stop;
  logic [W-1:0] data;

  logic [W-1:0] count_sec, count_dec;
  logic [1:0]   state_sec, state_dec;
  logic         zero_sec,  zero_dec;
  logic         done_sec,  done_dec;

  bcd_down_timer #(.DIGITS(DIGITS), .SEC_MODE(1)) u_dut_sec (
    .clk   (clk),
    .clrn  (clrn),
    .data  (data),
    .loadn (loadn),
    .en    (en),
    .start (start),
    .stop  (stop),
    .count (count_sec),
    .state (state_sec),
    .zero  (zero_sec),
    .done  (done_sec)
  );

  bcd_down_timer #(.DIGITS(DIGITS), .SEC_MODE(0)) u_dut_dec (
    .clk   (clk),
    .clrn  (clrn),
    .data  (data),
    .loadn (loadn),
    .en    (en),
    .start (start),
    .stop  (stop),
    .count (count_dec),
    .state (state_dec),
    .zero  (zero_dec),
    .done  (done_dec)
  );

  // ---------------- reference model ----------------
  // Model index 0 = mm:ss timer, 1 = decimal timer.
  int md [2][DIGITS];
  int ms [2];
  bit mdone [2];
  int sec_mode [2] = '{1, 0};

  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] m_count(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'(md[k][i]);
    return r;
  endfunction

  function automatic bit m_zero(input int k);
    for (int i = 0; i < DIGITS; i++) if (md[k][i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_clamp(input int k, input int i, input int v);
    if (LOAD_CHK && sec_mode[k] == 1 && i == 1 && v > 5) return 5;
    if (LOAD_CHK && v > 9) return 9;
    return v;
  endfunction

  task automatic m_load(input int k);
    for (int i = 0; i < DIGITS; i++) md[k][i] = m_clamp(k, i, int'(data[4*i +: 4]));
  endtask

  task automatic m_clear(input int k);
    for (int i = 0; i < DIGITS; i++) md[k][i] = 0;
  endtask

  // Subtract one: the lowest non-zero digit loses one, every zero digit
  // below it wraps to its top value.
  task automatic m_dec(input int k);
    for (int i = 0; i < DIGITS; i++) begin
      if (md[k][i] > 0) begin
        md[k][i] = md[k][i] - 1;
        return;
      end
      md[k][i] = (sec_mode[k] == 1 && i == 1) ? 5 : 9;
    end
  endtask

  task automatic m_step(input int k);
    mdone[k] = 1'b0;
    if (!clrn) begin
      m_clear(k);
      ms[k] = S_IDLE;
      return;
    end
    if (ms[k] == S_RUN) begin
      if (stop) ms[k] = S_PAUSE;
      else if (en && !m_zero(k)) begin
        m_dec(k);
        if (m_zero(k)) begin
          ms[k]    = S_DONE;
          mdone[k] = 1'b1;
        end
      end
    end else if (ms[k] == S_IDLE) begin
      if (!stop) begin
        if (!loadn) m_load(k);
        else if (start && !m_zero(k)) ms[k] = S_RUN;
      end
    end else if (ms[k] == S_PAUSE) begin
      if (stop) begin
        m_clear(k);
        ms[k] = S_IDLE;
      end else if (!loadn) begin
        m_load(k);
        ms[k] = S_IDLE;
      end else if (start && !m_zero(k)) ms[k] = S_RUN;
    end else begin
      if (stop) begin
        m_clear(k);
        ms[k] = S_IDLE;
      end else if (!loadn) begin
        m_load(k);
        ms[k] = S_IDLE;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_q.push_back(m_count(0));
    exp_q.push_back(m_count(1));
    chk("count_sec", count_sec, exp_q.pop_front());
    chk("count_dec", count_dec, exp_q.pop_front());
    chk("state_sec", W'(state_sec), W'(ms[0]));
    chk("state_dec", W'(state_dec), W'(ms[1]));
    chk("zero_sec",  W'(zero_sec),  W'(m_zero(0)));
    chk("zero_dec",  W'(zero_dec),  W'(m_zero(1)));
    chk("done_sec",  W'(done_sec),  W'(mdone[0]));
    chk("done_dec",  W'(done_dec),  W'(mdone[1]));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after the rising edge; outputs are checked there too.
  task automatic cycle(input logic c_clrn, input logic c_loadn, input logic [W-1:0] c_data,
                       input logic c_en, input logic c_start, input logic c_stop);
    clrn  = c_clrn;
    loadn = c_loadn;
    data  = c_data;
    en    = c_en;
    start = c_start;
    stop  = c_stop;
    m_step(0);
    m_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [W-1:0] v); cycle(1, 0, v, 0, 0, 0); endtask
  task automatic do_start();                    cycle(1, 1, '0, 0, 1, 0); endtask
  task automatic do_tick();                     cycle(1, 1, '0, 1, 0, 0); endtask
  task automatic do_idle();                     cycle(1, 1, '0, 0, 0, 0); endtask
  task automatic do_stop();                     cycle(1, 1, '0, 0, 0, 1); endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    int v;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 15) == 0)      v = $urandom_range(10, 15);
      else if (i >= 2)                     v = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      else if (i == 1)                     v = $urandom_range(0, 5);
      else                                 v = $urandom_range(0, 9);
      r[4*i +: 4] = 4'(v);
    end
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    clrn = 0; loadn = 1; en = 0; start = 0; stop = 0; data = '0;

    // Reset, with other inputs active to show reset overrides them.
    cycle(0, 1, '0, 0, 0, 0);
    cycle(0, 0, 16'h0555, 1, 1, 0);
    chk("rst_count", count_sec, 16'h0000);
    chk("rst_state", W'(state_sec), W'(2'b00));
    chk("rst_zero",  W'(zero_sec), W'(1'b1));
    chk("rst_done",  W'(done_sec), W'(1'b0));

    // 1:30 down to 0:00 in the mm:ss timer, idle cycles between ticks.
    do_load(16'h0130);
    do_start();
    pulses = 0;
    for (int n = 0; n < 90; n++) begin
      do_tick();
      if (done_sec) pulses++;
      if (n == 30) chk("mmss_0059", count_sec, 16'h0059);
      do_idle();
      if (done_sec) pulses++;
    end
    chk("mmss_done_pulses", W'(pulses), W'(1));
    chk("mmss_final_count", count_sec, 16'h0000);
    chk("mmss_final_state", W'(state_sec), W'(2'b11));
    chk("dec_after_90", count_dec, 16'h0040);
    // start in DONE is ignored
    do_start();
    chk("done_ignores_start", W'(state_sec), W'(2'b11));
    do_stop();
    do_stop();

    // 0100 - 1: decimal gives 0099, mm:ss gives 0059.
    do_load(16'h0100);
    do_start();
    do_tick();
    chk("dec_0100_m1", count_dec, 16'h0099);
    chk("sec_0100_m1", count_sec, 16'h0059);
    do_stop();
    do_stop();

    // Pause/resume/clear from 0045.
    do_load(16'h0045);
    do_start();
    cycle(1, 1, '0, 1, 0, 1);
    chk("pause_count", count_sec, 16'h0045);
    chk("pause_state", W'(state_sec), W'(2'b10));
    do_start();
    do_tick();
    chk("resume_count", count_sec, 16'h0044);
    do_stop();
    do_stop();
    chk("clear_count", count_sec, 16'h0000);
    chk("clear_state", W'(state_sec), W'(2'b00));

    // start with zero count stays idle; load during RUN is ignored.
    do_load(16'h0000);
    do_start();
    chk("zero_start_state", W'(state_sec), W'(2'b00));
    chk("zero_start_done",  W'(done_sec), W'(1'b0));
    do_load(16'h0200);
    do_start();
    cycle(1, 0, 16'h0999, 1, 0, 0);
    chk("run_load_ignored", count_sec, 16'h0159);
    // simultaneous stop/load/start: stop wins
    cycle(1, 0, 16'h0777, 0, 1, 1);
    chk("prio_stop_state", W'(state_sec), W'(2'b10));
    // in PAUSE: load beats start
    cycle(1, 0, 16'h0321, 0, 1, 0);
    chk("prio_load", count_sec, 16'h0321);
    chk("prio_load_state", W'(state_sec), W'(2'b00));

    // Reset mid-RUN.
    do_load(16'h0313);
    do_start();
    do_tick();
    chk("pre_rst_count", count_sec, 16'h0312);
    cycle(0, 1, '0, 1, 1, 0);
    chk("midrun_rst_count", count_sec, 16'h0000);
    chk("midrun_rst_state", W'(state_sec), W'(2'b00));
    chk("midrun_rst_zero",  W'(zero_sec), W'(1'b1));
    chk("midrun_rst_done",  W'(done_sec), W'(1'b0));

    // Illegal digits on load.
    cycle(1, 0, 16'h007F, 0, 0, 0);
    chk("load_7f", count_sec, LOAD_CHK ? 16'h0059 : 16'h007F);
    do_start();
    for (int n = 0; n < 4; n++) do_tick();
    do_stop();
    do_stop();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 199) != 0,
            $urandom_range(0, 9) != 0,
            rand_data(),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of BCD digits (legal 2..8).
REQ-002 SHALL have parameter SEC_MODE, default 1, meaning digit 1 (tens of seconds) counts modulo 6 (mm:ss format); 0 means all digits count modulo 10.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clrn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port data, input, 4*DIGITS bits: load value; digit 0 in bits [3:0].
REQ-006 SHALL have port loadn, input, 1 bit: active-low synchronous load request.
REQ-007 SHALL have port en, input, 1 bit: count tick strobe (for example 1 Hz), one cycle wide.
REQ-008 SHALL have port start, input, 1 bit: begin or resume counting.
REQ-009 SHALL have port stop, input, 1 bit: pause; a second stop clears the count.
REQ-010 SHALL have port count, output, 4*DIGITS bits: current BCD value.
REQ-011 SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 SHALL have port zero, output, 1 bit: high when count equals 0.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on expiry.

Function
REQ-014 SHALL be an FSM with states IDLE, RUN, PAUSE and DONE.
REQ-015 In IDLE, PAUSE or DONE, loadn=0 SHALL load data into count on the next edge and go to IDLE.
REQ-016 In RUN, loadn SHALL be ignored.
REQ-017 In IDLE or PAUSE, start=1 with count≠0 SHALL go to RUN; start=1 with count=0 SHALL remain in the current state.
REQ-018 In RUN, each en=1 cycle SHALL decrement count by 1 in BCD, with borrow rippling across all digits in the same cycle.
REQ-019 A digit that borrows SHALL wrap to 9, or to 5 for digit 1 when SEC_MODE=1.
REQ-020 In RUN, en=1 with count=1 SHALL make count 0 and go to DONE, and done SHALL pulse high in the cycle DONE is entered.
REQ-021 count SHALL never decrement below 0, and SHALL never change with en=0.
REQ-022 In RUN, stop=1 SHALL go to PAUSE with count held; an en in the same cycle SHALL be ignored.
REQ-023 In PAUSE, stop=1 SHALL clear count to 0 and go to IDLE.
REQ-024 When start, stop and loadn=0 coincide, priority SHALL be stop, then loadn, then start.
REQ-025 In DONE, start SHALL be ignored; leaving DONE SHALL require loadn=0 or stop=1, and stop=1 goes to IDLE with count=0.
REQ-026 zero SHALL be combinational from count; done SHALL be registered.

Reset
REQ-027 clrn=0 at a rising clk edge SHALL force count=0, state=IDLE and done=0, overriding all other inputs.
REQ-028 Reset SHALL have the same effect mid-RUN; after reset, zero=1.
REQ-029 Outputs SHALL not change between clock edges while clrn is low.

Configuration
REQ-030 Macro BCD_TIMER_LOAD_CHECK_EN, when defined, SHALL clamp each loaded digit >9 to 9, and digit 1 >5 to 5 when SEC_MODE=1.
REQ-031 Without BCD_TIMER_LOAD_CHECK_EN, data SHALL be loaded unmodified.
REQ-032 Without the macro, decrement of an illegal digit SHALL still follow REQ-018/019, treating the digit as binary minus 1 with borrow only at 0.

Verification
REQ-033 Reset then load 0130 (1:30), start, 90 en pulses -> count steps 0130, 0129 … 0100, 0059 … 0000; done pulses exactly once; state=DONE.
REQ-034 SEC_MODE=0: load 0100, start, 1 en -> count 0099.
REQ-035 RUN at 0045: stop with en in the same cycle -> PAUSE, count 0045; start then 1 en -> 0044; stop, stop -> IDLE, count 0000.
REQ-036 Load 0000, start -> remains IDLE, done=0; loadn=0 during RUN -> count unaffected.
REQ-037 clrn=0 mid-RUN at 0312 -> next edge count 0000, IDLE, zero=1, done=0.
REQ-038 With BCD_TIMER_LOAD_CHECK_EN, load 0x07F -> count 0059; without it, count 007F.
